// File: rtl/mutex_mon_pkg.sv
// Shared types and constants for the mutex/hold protocol monitor.
// Capture record is sized for the widest supported configuration.
package mutex_mon_pkg;

  localparam int MAX_N    = 32;
  localparam int MAX_TS_W = 32;

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_MUTEX = 2'b01;
  localparam logic [1:0] KIND_HOLD  = 2'b10;

  typedef logic [1:0] kind_t;

  typedef struct packed {
    kind_t                 kind;
    logic [MAX_N-1:0]      mask;
    logic [MAX_TS_W-1:0]   ts;
  } cap_t;

  function automatic kind_t kind_of(
    input logic is_mutex,
    input logic is_hold
  );
    kind_t k;
    k = KIND_NONE;
    if (is_mutex) k = k | KIND_MUTEX;
    if (is_hold)  k = k | KIND_HOLD;
    return k;
  endfunction

endpackage

// File: rtl/mon_popcount_ge2.sv
// Flags an N-bit vector with two or more bits set.
// Clearing the lowest set bit leaves a nonzero value only if another bit is set.
module mon_popcount_ge2 #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec_i,
  output logic         ge2_o
);

  logic [N-1:0] less_one;

  assign less_one = vec_i - N'(1);
  assign ge2_o    = |(vec_i & less_one);

endmodule

// File: rtl/mutex_hold_monitor.sv
// Protocol monitor: at most one valid per cycle, and valids held until ready.
// Sticky flags, saturating count and a first-violation capture record.
module mutex_hold_monitor
  import mutex_mon_pkg::*;
#(
  parameter int N          = 4,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16,
  parameter bit HOLD_CHECK = 1'b1,
  parameter bit FATAL_EN   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic [N-1:0]     io_valid,
  input  logic [N-1:0]     io_ready,
  input  logic             io_clear,
  output logic             io_err_mutex,
  output logic             io_err_hold,
  output logic [CNT_W-1:0] io_err_count,
  output logic             io_first_valid,
  output logic [1:0]       io_first_kind,
  output logic [N-1:0]     io_first_mask,
  output logic [TS_W-1:0]  io_first_ts,
  output logic             io_viol
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             err_mutex_q, err_mutex_d;
  logic             err_hold_q, err_hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_valid_q, cap_valid_d;
  cap_t             cap_q, cap_d;
  logic             viol_q, viol_d;

  logic             multi;
  logic             mutex_hit;
  logic             hold_hit;
  logic             viol;
  logic [N-1:0]     drop_mask;
  logic [N-1:0]     offend_mask;
  logic             cap_unused;

  mon_popcount_ge2 #(
    .N (N)
  ) u_ge2 (
    .vec_i (io_valid),
    .ge2_o (multi)
  );

  always_comb begin
    drop_mask   = pend_q & ~io_valid;
    mutex_hit   = io_en & multi;
    hold_hit    = HOLD_CHECK & io_en & (|drop_mask);
    viol        = mutex_hit | hold_hit;
    offend_mask = ({N{mutex_hit}} & io_valid)
                | ({N{hold_hit}} & drop_mask);
  end

  // Pending mask drops to zero whenever checking is off, so re-enable is clean.
  always_comb begin
    ts_d   = ts_q + TS_W'(1);
    pend_d = io_valid & ~io_ready & {N{io_en}};
    if (io_clear) pend_d = '0;
  end

  always_comb begin
    err_mutex_d = err_mutex_q;
    err_hold_d  = err_hold_q;
    cnt_d       = cnt_q;
    cap_valid_d = cap_valid_q;
    cap_d       = cap_q;
    viol_d      = 1'b0;
    if (io_clear) begin
      err_mutex_d = 1'b0;
      err_hold_d  = 1'b0;
      cnt_d       = '0;
      cap_valid_d = 1'b0;
      cap_d       = '0;
    end else if (viol) begin
      viol_d      = 1'b1;
      err_mutex_d = err_mutex_q | mutex_hit;
      err_hold_d  = err_hold_q | hold_hit;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (!cap_valid_q) begin
        cap_valid_d = 1'b1;
        cap_d.kind  = kind_of(mutex_hit, hold_hit);
        cap_d.mask  = MAX_N'(offend_mask);
        cap_d.ts    = MAX_TS_W'(ts_q);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q        <= '0;
      pend_q      <= '0;
      err_mutex_q <= 1'b0;
      err_hold_q  <= 1'b0;
      cnt_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
      viol_q      <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      pend_q      <= pend_d;
      err_mutex_q <= err_mutex_d;
      err_hold_q  <= err_hold_d;
      cnt_q       <= cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_q       <= cap_d;
      viol_q      <= viol_d;
    end
  end

  assign io_err_mutex   = err_mutex_q;
  assign io_err_hold    = err_hold_q;
  assign io_err_count   = cnt_q;
  assign io_first_valid = cap_valid_q;
  assign io_first_kind  = cap_q.kind;
  assign io_first_mask  = cap_q.mask[N-1:0];
  assign io_first_ts    = cap_q.ts[TS_W-1:0];
  assign io_viol        = viol_q;

  // Record fields above N/TS_W bits are always zero.
  assign cap_unused = ^{cap_q.mask, cap_q.ts};

`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND (!reset)
`endif
`ifndef STOP_COND
`define STOP_COND (!reset)
`endif
  always @(posedge clock) begin
    if (viol && `PRINTF_COND) begin
      if (!FATAL_EN || !cap_valid_q)
        $info("mutex_hold_monitor viol kind=%b mask=%b ts=%0d",
              kind_of(mutex_hit, hold_hit), offend_mask, ts_q);
    end
    if (viol && !cap_valid_q && FATAL_EN && `STOP_COND)
      $fatal(1, "mutex_hold_monitor stop on first violation");
  end
`endif

endmodule

// File: doc/mutex_hold_monitor.md
Name: mutex_hold_monitor

Overview:
- Parametrised protocol monitor for N valid/ready channels sharing one resource.
- Checks per cycle that at most one channel is valid. When HOLD_CHECK=1, also checks that a valid not yet accepted by ready stays asserted into the next cycle.
- Records violations in sticky flags and a saturating counter, and captures the first violation.
- Instantiated alongside arbiters and crossbars in the bench. It is also synthesisable, so its status can be read in emulation.

Parameters:
- N, 4, number of monitored channels (2..32).
- CNT_W, 8, width of the saturating violation counter.
- TS_W, 16, width of the free-running cycle timestamp.
- HOLD_CHECK, 1, enables the valid-hold rule (0 = mutex check only).
- FATAL_EN, 1, non-synthesis only: $fatal on the first violation.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_en  in  1  checking enable. While low, no violation is recorded; the timestamp still runs.
- io_valid  in  N  per-channel valid.
- io_ready  in  N  per-channel ready.
- io_clear  in  1  synchronous clear of flags, counter and capture.
- io_err_mutex  out  1  sticky: at least two valids were high in one cycle.
- io_err_hold  out  1  sticky: a pending valid dropped before ready.
- io_err_count  out  CNT_W  count of violating cycles, saturating.
- io_first_valid  out  1  capture registers hold data.
- io_first_kind  out  2  bit0 = mutex, bit1 = hold, at the first violation.
- io_first_mask  out  N  offending channel mask at the first violation.
- io_first_ts  out  TS_W  timestamp of the first violation.
- io_viol  out  1  registered pulse, high one cycle after a violating cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release): every output and internal register is 0, including the timestamp and the pending mask.
- Timestamp ts: increments every cycle and wraps at 2^TS_W.
- Pending mask pend[i]:
  - Next value is valid[i] & ~ready[i] & en.
  - Cleared by io_clear.
- Mutex violation in cycle t: en & (popcount(valid) >= 2).
  - Offending mask = valid.
- Hold violation in cycle t:
  - Requires HOLD_CHECK = 1 and en.
  - Condition: (pend & ~valid) != 0.
  - Offending mask = pend & ~valid.
- viol_t = mutex | hold.
- All status registers update at the end of the violating cycle, so they are visible in cycle t+1 (latency 1):
  - io_err_mutex and io_err_hold are set by their own condition and stay set until io_clear.
  - io_err_count increments by 1 per violating cycle, even when both kinds occur. It holds at 2^CNT_W-1.
  - Capture happens only when io_first_valid = 0. It loads kind = {hold, mutex}, mask = the OR of both offending masks, and ts = ts of cycle t. It then sets io_first_valid. Later violations never overwrite the capture.
  - io_viol = viol registered.
- io_clear in the same cycle as a violation: clear wins. All status goes to 0 and that violation is dropped.
- io_en falling: pend is cleared the next cycle, so there is no spurious hold error when checking is re-enabled.
- Reset asserted mid-operation: all state clears immediately. No fatal or printf fires while reset is high.
- Simulation-only block (non-synthesis, gated by STOP_COND / PRINTF_COND):
  - On viol with io_first_valid = 0 and FATAL_EN = 1: a one-line message with kind, mask and ts, then $fatal.
  - With FATAL_EN = 0: a message on every violation.

Decomposition:
- Package mutex_mon_pkg holds:
  - the kind encoding constants KIND_MUTEX = 2'b01 and KIND_HOLD = 2'b10;
  - a typedef for the capture record {kind, mask, ts}.
- One sub-module, mon_popcount_ge2. It is combinational and reports whether at least two bits of an N-bit vector are set, using the reduction valid & (valid - 1) != 0.

Test Plan:
- N=4, en=1, valid=0001 then 0010, with ready=1 each cycle -> no flags, count 0, io_viol never high.
- valid=0101 in a single cycle at ts=5 -> next cycle: err_mutex=1, count=1, first_kind=01, first_mask=0101, first_ts=5, io_viol high for 1 cycle.
- valid[2]=1 with ready=0 at ts=9, then valid=0 at ts=10 -> err_hold=1, first_kind=10, mask=0100, first_ts=10.
- 300 consecutive cycles with valid=1111 and CNT_W=8 -> count saturates at 255. Capture stays at the first cycle, kind 01.
- Violation and io_clear asserted in the same cycle -> all status 0 next cycle. A following violation is captured fresh.
- Reset pulsed asynchronously mid-cycle while err flags are set and pend=0100 -> outputs 0 immediately. Holding valid low after release gives no hold error.
